twos_neg_arbiter: RTL and testbench

TWOS_NEG_ARBITER -- requirements
Module: twos_neg_arbiter

---
 rtl/twos_neg_arbiter.sv | 117 +++++++++++
 tb/tb_twos_neg_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/twos_neg_arbiter.sv
// Four-requester round-robin arbiter that returns the two's complement of the granted operand.
// Optional overflow flag output enabled by defining TWOS_NEG_ARBITER_OVF_EN.
module twos_neg_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] a,
    output logic [3:0]         gnt,
    output logic [WIDTH-1:0]   y,
    output logic [1:0]         y_id,
    output logic               y_valid,
    input  logic               y_ready,
    output logic               busy
`ifdef TWOS_NEG_ARBITER_OVF_EN
    ,
    output logic               ovf
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       last;
    logic [1:0]       win;
    logic             win_found;
    logic             take;
    logic             done;
    logic [WIDTH-1:0] opnd [4];
    logic [WIDTH-1:0] sel;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            opnd[i] = a[i*WIDTH +: WIDTH];
        end
    end

    // Scan from last+1 upward; the previous winner is considered last.
    always_comb begin : rr_pick
        logic [1:0] idx;
        idx       = last;
        win       = last;
        win_found = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!win_found && req[idx]) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end

    assign sel = opnd[win];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req)   state_nxt = RESP;
            RESP:    if (y_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        take = (state == IDLE) && win_found;
        done = (state == RESP) && y_ready;
    end

    // Result registers; the handshake only clears y_valid so y/y_id keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt     <= '0;
            y       <= '0;
            y_id    <= '0;
            y_valid <= 1'b0;
            last    <= 2'd3;
        end else begin
            gnt <= '0;
            if (take) begin
                gnt     <= 4'b0001 << win;
                y       <= ~sel + WIDTH'(1);
                y_id    <= win;
                y_valid <= 1'b1;
            end else if (done) begin
                y_valid <= 1'b0;
                last    <= y_id;
            end
        end
    end

`ifdef TWOS_NEG_ARBITER_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (take) begin
            ovf <= (sel == MOST_NEG);
        end
    end
`endif

endmodule

// File: tb/tb_twos_neg_arbiter.sv
// Directed bench for twos_neg_arbiter: rotating-priority reference model checked every cycle,
// plus literal expectations on hand-computed vectors.
module tb_twos_neg_arbiter;

    localparam int W  = 8;
    localparam int AW = 4 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [AW-1:0] a;
    logic [3:0]    gnt;
    logic [W-1:0]  y;
    logic [1:0]    y_id;
    logic          y_valid;
    logic          y_ready;
    logic          busy;
`ifdef TWOS_NEG_ARBITER_OVF_EN
    logic          ovf;
`endif

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    twos_neg_arbiter #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a       (a),
        .gnt     (gnt),
        .y       (y),
        .y_id    (y_id),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .busy    (busy)
`ifdef TWOS_NEG_ARBITER_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: priority list rotated so the last served requester sits at the back.
    int           m_order[$] = '{0, 1, 2, 3};
    bit           m_busy  = 1'b0;
    logic [3:0]   m_gnt   = '0;
    logic [W-1:0] m_y     = '0;
    logic [1:0]   m_id    = '0;
    bit           m_valid = 1'b0;
    bit           m_ovf   = 1'b0;
    int           m_w;
    logic [W-1:0] m_av;

    always @(posedge clk) begin
        m_gnt = '0;
        if (rst) begin
            m_busy  = 1'b0;
            m_y     = '0;
            m_id    = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_order = '{0, 1, 2, 3};
        end else if (m_busy) begin
            if (y_ready) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
                while (m_order[3] != int'(m_id)) m_order.push_back(m_order.pop_front());
            end
        end else begin
            m_w = -1;
            for (int k = 0; k < 4; k++) begin
                if (m_w < 0 && req[m_order[k]]) m_w = m_order[k];
            end
            if (m_w >= 0) begin
                m_av    = a[m_w*W +: W];
                m_gnt   = 4'(1 << m_w);
                m_y     = W'((longint'(1) <<< W) - longint'(m_av));
                m_id    = 2'(m_w);
                m_valid = 1'b1;
                m_busy  = 1'b1;
                m_ovf   = (m_av == W'(1 << (W - 1)));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("gnt", 64'(gnt), 64'(m_gnt));
            cmp("y_valid", 64'(y_valid), 64'(m_valid));
            cmp("busy", 64'(busy), 64'(m_busy));
            if (m_valid) begin
                cmp("y", 64'(y), 64'(m_y));
                cmp("y_id", 64'(y_id), 64'(m_id));
`ifdef TWOS_NEG_ARBITER_OVF_EN
                cmp("ovf", 64'(ovf), 64'(m_ovf));
`endif
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic exp_grant(input string tag, input logic [3:0] g, input logic [W-1:0] yv,
                             input logic [1:0] id, input logic ov);
        cmp({tag, ".gnt"}, 64'(gnt), 64'(g));
        cmp({tag, ".y"}, 64'(y), 64'(yv));
        cmp({tag, ".y_id"}, 64'(y_id), 64'(id));
        cmp({tag, ".y_valid"}, 64'(y_valid), 64'(1'b1));
        cmp({tag, ".busy"}, 64'(busy), 64'(1'b1));
`ifdef TWOS_NEG_ARBITER_OVF_EN
        cmp({tag, ".ovf"}, 64'(ovf), 64'(ov));
`else
        if (ov) begin end
`endif
    endtask

    task automatic exp_idle(input string tag);
        cmp({tag, ".gnt"}, 64'(gnt), 64'(4'b0000));
        cmp({tag, ".y_valid"}, 64'(y_valid), 64'(1'b0));
        cmp({tag, ".busy"}, 64'(busy), 64'(1'b0));
    endtask

    logic [1:0]   rr_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [W-1:0] rr_y  [5] = '{8'hF6, 8'h0A, 8'h00, 8'h80, 8'hF6};
    logic         rr_ov [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0]   gp_id [3] = '{2'd1, 2'd3, 2'd1};
    logic [W-1:0] gp_y  [3] = '{8'h81, 8'hFF, 8'h81};

    initial begin
        rst = 1'b1; req = '0; a = '0; y_ready = 1'b0;
        tick(); tick();
        cmp("reset.y", 64'(y), 64'(8'h00));
        cmp("reset.y_id", 64'(y_id), 64'(2'd0));
        exp_idle("reset");
        chk_en = 1'b1;

        // single request, immediate accept
        rst = 1'b0; req = 4'b0001; a = 32'h0000000A; y_ready = 1'b1;
        tick(); exp_grant("single", 4'b0001, 8'hF6, 2'd0, 1'b0);
        req = '0;
        tick(); exp_idle("single_done");

        // all requesting from reset priority: 0,1,2,3,0
        rst = 1'b1; tick();
        rst = 1'b0; req = 4'b1111; a = 32'h8000F60A; y_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); exp_grant("rr", 4'(1 << rr_id[i]), rr_y[i], rr_id[i], rr_ov[i]);
            tick(); exp_idle("rr_hs");
        end
        req = '0;

        // backpressure with churning inputs
        req = 4'b0010; a = 32'h00003300; y_ready = 1'b0;
        tick(); exp_grant("bp", 4'b0010, 8'hCD, 2'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            a = AW'($urandom); req = 4'b1111;
            tick(); exp_grant("bp_hold", 4'b0000, 8'hCD, 2'd1, 1'b0);
        end
        req = '0; y_ready = 1'b1;
        tick(); exp_idle("bp_done");

        // reset mid-response discards result and restores priority
        req = 4'b0001; a = 32'h00000001; y_ready = 1'b0;
        tick(); exp_grant("rst_pre", 4'b0001, 8'hFF, 2'd0, 1'b0);
        rst = 1'b1; req = '0;
        tick(); exp_idle("rst_mid");
        cmp("rst_mid.y", 64'(y), 64'(8'h00));
        rst = 1'b0; req = 4'b1000; a = 32'h80000000;
        tick(); exp_grant("rst_post", 4'b1000, 8'h80, 2'd3, 1'b1);
        y_ready = 1'b1; req = '0;
        tick(); exp_idle("rst_post_done");

        // request raised during RESP and dropped as RESP completes
        req = 4'b0001; a = 32'h00000005; y_ready = 1'b0;
        tick(); exp_grant("drop_pre", 4'b0001, 8'hFB, 2'd0, 1'b0);
        req = 4'b0100;
        tick(); exp_grant("drop_hold", 4'b0000, 8'hFB, 2'd0, 1'b0);
        y_ready = 1'b1;
        tick(); exp_idle("drop_hs");
        req = '0;
        tick(); exp_idle("drop_after");
        tick(); exp_idle("drop_after2");

        // sparse requests skip idle slots: after id0, 1 then 3 then 1
        req = 4'b1010; a = 32'h01007F00; y_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); exp_grant("gap", 4'(1 << gp_id[i]), gp_y[i], gp_id[i], 1'b0);
            tick(); exp_idle("gap_hs");
        end
        req = '0;
        tick();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
